// File: rtl/tx_kick_pkg.sv
// Shared types and helpers for the tx kick sequencer.
package tx_kick_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StKick = 2'd1,
    StWait = 2'd2,
    StGap  = 2'd3
  } state_e;

  localparam logic ModeCont    = 1'b0;
  localparam logic ModeCounted = 1'b1;

  // Bits needed to hold the longest of the three intervals the timer is shared between.
  function automatic int unsigned cnt_width(int unsigned pulse_len, int unsigned gap_cycles,
                                            int unsigned timeout);
    int unsigned m;
    m = pulse_len;
    if (gap_cycles > m) m = gap_cycles;
    if (timeout > m) m = timeout;
    return unsigned'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/tx_kick_timer.sv
// Loadable down-counter shared by the pulse, gap and watchdog intervals.
module tx_kick_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_kick_seq.sv
// Issues fixed-width itx kicks and waits for tx_done, in continuous or counted runs,
// with an optional inter-kick gap and a completion watchdog.
module tx_kick_seq
  import tx_kick_pkg::*;
#(
  parameter int unsigned PULSE_LEN  = 3,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_tx_i,
  input  logic             tx_done_i,
  output logic             itx_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] tx_count_o,
  output logic             done_o,
  output logic             timeout_err_o
);

  localparam int unsigned TmrW = cnt_width(PULSE_LEN, GAP_CYCLES, TIMEOUT);
  localparam logic [TmrW-1:0] PulseVal = TmrW'(PULSE_LEN - 1);
  localparam logic [TmrW-1:0] GapVal   = (GAP_CYCLES > 0) ? TmrW'(GAP_CYCLES - 1) : '0;
  localparam logic [TmrW-1:0] WaitVal  = (TIMEOUT > 0) ? TmrW'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic             itx_q, itx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic             latch_q, latch_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] num_q, num_d;

  logic             tmr_load;
  logic [TmrW-1:0]  tmr_val;
  logic             tmr_zero;

  tx_kick_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (~tmr_load),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    itx_d    = 1'b0;
    done_d   = 1'b0;
    terr_d   = terr_q;
    latch_d  = latch_q;
    mode_d   = mode_q;
    count_d  = count_q;
    num_d    = num_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StIdle: begin
        latch_d = 1'b0;
        if (enable_i && (mode_i == ModeCont)) begin
          mode_d   = ModeCont;
          state_d  = StKick;
          itx_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PulseVal;
        end else if (enable_i && (mode_i == ModeCounted) && start_i) begin
          mode_d  = ModeCounted;
          num_d   = num_tx_i;
          count_d = '0;
          terr_d  = 1'b0;
          if (num_tx_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = StKick;
            itx_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = PulseVal;
          end
        end
      end

      StKick: begin
        itx_d = 1'b1;
        // An early tx_done is held so WAIT can complete on its first cycle.
        if (tx_done_i) latch_d = 1'b1;
        if (tmr_zero) begin
          itx_d    = 1'b0;
          state_d  = StWait;
          tmr_load = 1'b1;
          tmr_val  = WaitVal;
        end
      end

      StWait: begin
        if (tx_done_i || latch_q) begin
          latch_d = 1'b0;
          count_d = count_q + 1'b1;
          if ((mode_q == ModeCounted) && (count_d == num_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (!enable_i) begin
            state_d = StIdle;
          end else if (GAP_CYCLES > 0) begin
            state_d  = StGap;
            tmr_load = 1'b1;
            tmr_val  = GapVal;
          end else begin
            state_d  = StKick;
            itx_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = PulseVal;
          end
        end else if ((TIMEOUT != 0) && tmr_zero) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end

      StGap: begin
        if (tmr_zero) begin
          if (enable_i) begin
            state_d  = StKick;
            itx_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = PulseVal;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      itx_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      latch_q <= 1'b0;
      mode_q  <= ModeCont;
      count_q <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      itx_q   <= itx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      latch_q <= latch_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      num_q   <= num_d;
    end
  end

  assign itx_o         = itx_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;
  assign tx_count_o    = count_q;

endmodule

// File: tb/tb_tx_kick_seq.sv
// Directed bench for tx_kick_seq: continuous/counted runs, early tx_done, watchdog, reset.
module tb_tx_kick_seq;

  localparam int unsigned PulseLen = 3;
  localparam int unsigned CntW     = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic            mode = 1'b0;
  logic            start = 1'b0;
  logic [CntW-1:0] num_tx = '0;
  logic            tx_done = 1'b0;
  logic            itx, busy, done, timeout_err;
  logic [CntW-1:0] tx_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tx_kick_seq #(
    .PULSE_LEN (PulseLen),
    .GAP_CYCLES(2),
    .TIMEOUT   (16),
    .CNT_W     (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .mode_i       (mode),
    .start_i      (start),
    .num_tx_i     (num_tx),
    .tx_done_i    (tx_done),
    .itx_o        (itx),
    .busy_o       (busy),
    .tx_count_o   (tx_count),
    .done_o       (done),
    .timeout_err_o(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first KICK cycle; returns on the cycle after tx_done is sampled.
  task automatic run_kick(input string tag, input int wait_n, input bit drop_en);
    for (int i = 0; i < int'(PulseLen); i++) begin
      check({tag, "_itx_hi"}, 32'(itx), 1);
      step();
    end
    check({tag, "_itx_lo"}, 32'(itx), 0);
    repeat (wait_n - 1) step();
    if (drop_en) enable = 1'b0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_itx", 32'(itx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(tx_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_terr", 32'(timeout_err), 0);
    rst = 1'b0;

    // Continuous mode with a 2-cycle gap
    step();
    run_kick("cont1", 2, 1'b0);
    check("cont1_count", 32'(tx_count), 1);
    check("cont1_gap_busy", 32'(busy), 1);
    check("cont1_gap1_itx", 32'(itx), 0);
    step();
    check("cont1_gap2_itx", 32'(itx), 0);
    step();
    run_kick("cont2", 2, 1'b0);
    check("cont2_count", 32'(tx_count), 2);
    step();
    step();

    // enable dropped in WAIT: tx_done counts, then idle with no re-kick
    run_kick("endrop", 1, 1'b1);
    check("endrop_count", 32'(tx_count), 3);
    check("endrop_busy", 32'(busy), 0);
    step();
    step();
    check("endrop_itx", 32'(itx), 0);
    check("endrop_busy2", 32'(busy), 0);

    // tx_done in 2nd KICK cycle: full pulse, 1-cycle WAIT, single increment
    enable = 1'b1;
    step();
    check("early_k1", 32'(itx), 1);
    step();
    tx_done = 1'b1;
    check("early_k2", 32'(itx), 1);
    step();
    tx_done = 1'b0;
    check("early_k3", 32'(itx), 1);
    step();
    check("early_wait_itx", 32'(itx), 0);
    check("early_wait_count", 32'(tx_count), 3);
    step();
    check("early_gap_count", 32'(tx_count), 4);
    check("early_gap_busy", 32'(busy), 1);
    step();
    step();

    // enable dropped mid-KICK does not truncate; then watchdog expiry
    check("wd_k1", 32'(itx), 1);
    enable = 1'b0;
    step();
    check("wd_k2", 32'(itx), 1);
    step();
    check("wd_k3", 32'(itx), 1);
    step();
    check("wd_wait_itx", 32'(itx), 0);
    check("wd_wait_count", 32'(tx_count), 4);
    repeat (15) step();
    check("wd_c16_terr", 32'(timeout_err), 0);
    check("wd_c16_busy", 32'(busy), 1);
    step();
    check("wd_terr", 32'(timeout_err), 1);
    check("wd_busy", 32'(busy), 0);
    check("wd_count", 32'(tx_count), 4);
    mode = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    check("wd_no_itx", 32'(itx), 0);
    check("wd_terr_sticky", 32'(timeout_err), 1);

    // Counted run of 4; start and num_tx changes while busy are ignored
    num_tx = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    num_tx = 8'd2;
    check("cnt_k1_itx", 32'(itx), 1);
    check("cnt_terr_clr", 32'(timeout_err), 0);
    check("cnt_count_clr", 32'(tx_count), 0);
    for (int i = 1; i <= 4; i++) begin
      run_kick("cnt", 1, 1'b0);
      check("cnt_count", 32'(tx_count), 32'(i));
      if (i < 4) begin
        check("cnt_done_lo", 32'(done), 0);
        start = (i == 2);
        step();
        start = 1'b0;
        step();
      end
    end
    check("cnt_done", 32'(done), 1);
    check("cnt_end_busy", 32'(busy), 0);
    step();
    check("cnt_done_pulse", 32'(done), 0);
    check("cnt_end_itx", 32'(itx), 0);

    // Continuous entry keeps tx_count; reset in 2nd KICK cycle aborts at once
    mode = 1'b0;
    step();
    check("rk_k1_itx", 32'(itx), 1);
    check("rk_count_kept", 32'(tx_count), 4);
    step();
    rst = 1'b1;
    #2;
    check("rk_itx", 32'(itx), 0);
    check("rk_busy", 32'(busy), 0);
    check("rk_count", 32'(tx_count), 0);
    mode = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check("rk_post_itx", 32'(itx), 0);
    check("rk_post_busy", 32'(busy), 0);

    // Counted run of 1, then start with num_tx=0 re-clears and pulses done without a kick
    num_tx = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_kick("one", 1, 1'b0);
    check("one_count", 32'(tx_count), 1);
    check("one_done", 32'(done), 1);
    step();
    num_tx = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_count", 32'(tx_count), 0);
    check("zero_itx", 32'(itx), 0);
    check("zero_busy", 32'(busy), 0);
    step();
    check("zero_done_pulse", 32'(done), 0);
    check("zero_itx2", 32'(itx), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
